// File: rtl/bus_pkg.sv
// Shared types for the bus-cycle sequencer and its helpers:
// device regions, FSM states and the address-to-region map.
package bus_pkg;

  localparam int WCNT_W = 4;

  typedef enum logic [1:0] {
    REG_RAM,
    REG_VIA,
    REG_ACIA,
    REG_EEPROM
  } region_t;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    STROBE,
    HOLD
  } state_t;

  function automatic region_t region_of(input logic [2:0] addr);
    region_t r;
    r = REG_RAM;
    unique case (1'b1)
      !addr[2]:             r = REG_RAM;
      addr[2:1] == 2'b10:   r = REG_VIA;
      addr == 3'b110:       r = REG_ACIA;
      addr == 3'b111:       r = REG_EEPROM;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/bus_region_select.sv
// Maps a device region plus an activity flag onto the four
// active-low chip enables; at most one enable is ever low.
module bus_region_select
  import bus_pkg::*;
(
  input  region_t region,
  input  logic    active,
  output logic    ram_ce_n,
  output logic    via_ce_n,
  output logic    acia_ce_n,
  output logic    eeprom_ce_n
);

  always_comb begin
    ram_ce_n    = 1'b1;
    via_ce_n    = 1'b1;
    acia_ce_n   = 1'b1;
    eeprom_ce_n = 1'b1;
    if (active) begin
      unique case (region)
        REG_RAM:    ram_ce_n    = 1'b0;
        REG_VIA:    via_ce_n    = 1'b0;
        REG_ACIA:   acia_ce_n   = 1'b0;
        REG_EEPROM: eeprom_ce_n = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/bus_cycle_ctrl.sv
// Bus-cycle sequencer: setup, wait-stretched strobe and hold
// around a single decoded chip enable for the slow devices.
module bus_cycle_ctrl
  import bus_pkg::*;
#(
  parameter int unsigned WS_RAM    = 0,
  parameter int unsigned WS_VIA    = 1,
  parameter int unsigned WS_ACIA   = 2,
  parameter int unsigned WS_EEPROM = 3
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       req,
  input  logic       rw,
  input  logic [2:0] address,
  input  logic [7:0] din,
  output logic       eeprom_ce_n,
  output logic       ram_ce_n,
  output logic       via_ce_n,
  output logic       acia_ce_n,
  output logic       oe_n,
  output logic       we_n,
  output logic       busy,
  output logic       done,
  output logic [7:0] rdata
);

  state_t              state;
  state_t              nxt;
  logic [WCNT_W-1:0]   wcnt;
  logic [WCNT_W-1:0]   ws_sel;
  logic                rw_q;
  region_t             region_q;
  region_t             region_in;
  logic                last_strobe;

  assign region_in   = region_of(address);
  assign last_strobe = (state == STROBE) && (wcnt == '0);

  always_comb begin
    ws_sel = '0;
    unique case (region_in)
      REG_RAM:    ws_sel = WCNT_W'(WS_RAM);
      REG_VIA:    ws_sel = WCNT_W'(WS_VIA);
      REG_ACIA:   ws_sel = WCNT_W'(WS_ACIA);
      REG_EEPROM: ws_sel = WCNT_W'(WS_EEPROM);
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= nxt;
    end
  end

  always_comb begin
    nxt  = state;
    busy = 1'b1;
    done = 1'b0;
    oe_n = 1'b1;
    we_n = 1'b1;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (req) nxt = SETUP;
      end
      SETUP: begin
        nxt = STROBE;
      end
      STROBE: begin
        oe_n = !rw_q;
        we_n = rw_q;
        if (wcnt == '0) nxt = HOLD;
      end
      HOLD: begin
        done = 1'b1;
        nxt  = IDLE;
      end
    endcase
  end

  // Request fields are frozen at acceptance; later input changes are ignored.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wcnt     <= '0;
      rw_q     <= 1'b0;
      region_q <= REG_RAM;
      rdata    <= 8'h00;
    end else begin
      if (state == IDLE && req) begin
        wcnt     <= ws_sel;
        rw_q     <= rw;
        region_q <= region_in;
      end else if (state == STROBE && wcnt != '0) begin
        wcnt <= wcnt - 1'b1;
      end
      if (last_strobe && rw_q) begin
        rdata <= din;
      end
    end
  end

  bus_region_select u_sel (
    .region      (region_q),
    .active      (busy),
    .ram_ce_n    (ram_ce_n),
    .via_ce_n    (via_ce_n),
    .acia_ce_n   (acia_ce_n),
    .eeprom_ce_n (eeprom_ce_n)
  );

endmodule

// File: tb/tb_bus_cycle_ctrl.sv
// Bench for bus_cycle_ctrl: three instances (RAM wait 0, 2, 15)
// against a timeline model, plus directed literal checks.
module tb_bus_cycle_ctrl;

  localparam int N = 3;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       req = 1'b0;
  logic       rw = 1'b0;
  logic [2:0] address = 3'b000;
  logic [7:0] din = 8'h00;

  logic       eeprom_ce_n [N];
  logic       ram_ce_n [N];
  logic       via_ce_n [N];
  logic       acia_ce_n [N];
  logic       oe_n [N];
  logic       we_n [N];
  logic       busy [N];
  logic       done [N];
  logic [7:0] rdata [N];

  int n_tests = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    bus_cycle_ctrl #(
      .WS_RAM    (g == 0 ? 0 : (g == 1 ? 2 : 15)),
      .WS_VIA    (1),
      .WS_ACIA   (2),
      .WS_EEPROM (3)
    ) u_dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .req         (req),
      .rw          (rw),
      .address     (address),
      .din         (din),
      .eeprom_ce_n (eeprom_ce_n[g]),
      .ram_ce_n    (ram_ce_n[g]),
      .via_ce_n    (via_ce_n[g]),
      .acia_ce_n   (acia_ce_n[g]),
      .oe_n        (oe_n[g]),
      .we_n        (we_n[g]),
      .busy        (busy[g]),
      .done        (done[g]),
      .rdata       (rdata[g])
    );
  end

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Region index: 0 RAM, 1 VIA, 2 ACIA, 3 EEPROM
  function automatic int reg_for(logic [2:0] a);
    if (a < 3'd4) return 0;
    if (a < 3'd6) return 1;
    if (a == 3'd6) return 2;
    return 3;
  endfunction

  function automatic int ws_for(int d, int r);
    if (r == 0) return (d == 0) ? 0 : ((d == 1) ? 2 : 15);
    return r;
  endfunction

  function automatic logic ce_of(int d, int r);
    case (r)
      0: return ram_ce_n[d];
      1: return via_ce_n[d];
      2: return acia_ce_n[d];
      default: return eeprom_ce_n[d];
    endcase
  endfunction

  // Model: an accepted access occupies cycles k = 1 .. ws+3 after
  // the accept edge; strobe is k = 2 .. ws+2, done is k = ws+3.
  bit       m_active [N];
  int       m_k [N];
  int       m_ws [N];
  int       m_reg [N];
  bit       m_rw [N];
  logic [7:0] m_rdata [N];

  always @(posedge clk or negedge reset_n) begin
    for (int d = 0; d < N; d++) begin
      if (!reset_n) begin
        m_active[d] = 1'b0;
        m_k[d] = 0;
        m_rdata[d] = 8'h00;
      end else if (m_active[d]) begin
        if (m_k[d] == m_ws[d] + 2 && m_rw[d]) m_rdata[d] = din;
        if (m_k[d] == m_ws[d] + 3) m_active[d] = 1'b0;
        else m_k[d]++;
      end else if (req) begin
        m_active[d] = 1'b1;
        m_k[d] = 1;
        m_reg[d] = reg_for(address);
        m_ws[d] = ws_for(d, m_reg[d]);
        m_rw[d] = rw;
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (reset_n) begin
      for (int d = 0; d < N; d++) begin
        bit strobe;
        strobe = m_active[d] && m_k[d] >= 2 && m_k[d] <= m_ws[d] + 2;
        for (int r = 0; r < 4; r++)
          check($sformatf("dut%0d ce%0d", d, r), ce_of(d, r),
                !(m_active[d] && m_reg[d] == r));
        check($sformatf("dut%0d oe_n", d), oe_n[d], !(strobe && m_rw[d]));
        check($sformatf("dut%0d we_n", d), we_n[d], !(strobe && !m_rw[d]));
        check($sformatf("dut%0d busy", d), busy[d], m_active[d]);
        check($sformatf("dut%0d done", d), done[d],
              m_active[d] && m_k[d] == m_ws[d] + 3);
        check($sformatf("dut%0d rdata", d), rdata[d], m_rdata[d]);
      end
    end
  end

  int done_at [N];
  int ce_lo, oe_lo, we_lo, oth_lo;

  task automatic wait_idle();
    int n;
    n = 0;
    req = 1'b0;
    while ((busy[0] || busy[1] || busy[2]) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", n < 100, 1);
    @(negedge clk);
  endtask

  // One access; address switches to a_late in cycle 2 (strobe).
  task automatic access(bit w, logic [2:0] a, logic [2:0] a_late,
                        logic [7:0] d);
    int r;
    r = reg_for(a);
    for (int i = 0; i < N; i++) done_at[i] = 0;
    ce_lo = 0; oe_lo = 0; we_lo = 0; oth_lo = 0;
    @(negedge clk);
    req = 1'b1; rw = w; address = a; din = d;
    @(posedge clk);
    for (int c = 1; c <= 25; c++) begin
      @(negedge clk);
      if (c == 1) req = 1'b0;
      if (c == 2) address = a_late;
      for (int i = 0; i < N; i++)
        if (done[i] && done_at[i] == 0) done_at[i] = c;
      if (!ce_of(0, r)) ce_lo++;
      for (int o = 0; o < 4; o++)
        if (o != r && !ce_of(0, o)) oth_lo++;
      if (!oe_n[0]) oe_lo++;
      if (!we_n[0]) we_lo++;
    end
    wait_idle();
  endtask

  initial begin
    int stamps [3];
    int ns, hi;

    repeat (2) @(negedge clk);
    for (int d = 0; d < N; d++) begin
      check("rst ce", {ram_ce_n[d], via_ce_n[d], acia_ce_n[d],
                       eeprom_ce_n[d]}, 4'hF);
      check("rst oe_we", {oe_n[d], we_n[d]}, 2'b11);
      check("rst busy_done", {busy[d], done[d]}, 2'b00);
      check("rst rdata", rdata[d], 8'h00);
    end
    reset_n = 1'b1;
    @(negedge clk);

    // RAM read, default and overridden wait states
    access(1'b1, 3'b010, 3'b010, 8'hA5);
    check("ram done0", done_at[0], 3);
    check("ram done1", done_at[1], 5);
    check("ram done2", done_at[2], 18);
    check("ram ce_lo", ce_lo, 3);
    check("ram oe_lo", oe_lo, 1);
    check("ram other", oth_lo, 0);
    for (int d = 0; d < N; d++) check("ram rdata", rdata[d], 8'hA5);

    // EEPROM write
    access(1'b0, 3'b111, 3'b111, 8'h11);
    check("eep done", done_at[0], 6);
    check("eep we_lo", we_lo, 4);
    check("eep ce_lo", ce_lo, 6);
    check("eep oe_lo", oe_lo, 0);
    check("eep rdata", rdata[0], 8'hA5);

    // VIA accept, address moved to RAM during strobe
    access(1'b1, 3'b101, 3'b000, 8'h42);
    check("via done", done_at[0], 4);
    check("via ce_lo", ce_lo, 4);
    check("via other", oth_lo, 0);
    check("via rdata", rdata[0], 8'h42);

    // ACIA read, req held for three accesses
    @(negedge clk);
    req = 1'b1; rw = 1'b1; address = 3'b110; din = 8'h3C;
    @(posedge clk);
    ns = 0; hi = 0;
    for (int c = 1; c <= 40 && ns < 3; c++) begin
      @(negedge clk);
      if (acia_ce_n[0]) hi++;
      if (!ram_ce_n[0] || !via_ce_n[0] || !eeprom_ce_n[0]) hi += 100;
      if (done[0]) begin
        stamps[ns] = c;
        ns++;
      end
    end
    req = 1'b0;
    check("acia count", ns, 3);
    check("acia first", stamps[0], 5);
    check("acia gap1", stamps[1] - stamps[0], 6);
    check("acia gap2", stamps[2] - stamps[1], 6);
    check("acia idle_hi", hi, 2);
    check("acia rdata", rdata[0], 8'h3C);
    wait_idle();

    // Reset in second strobe cycle of an EEPROM read
    @(negedge clk);
    req = 1'b1; rw = 1'b1; address = 3'b111; din = 8'h77;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("pre_rst oe", oe_n[0], 1'b0);
    reset_n = 1'b0;
    #1;
    check("async ce", {ram_ce_n[0], via_ce_n[0], acia_ce_n[0],
                       eeprom_ce_n[0]}, 4'hF);
    check("async oe_we", {oe_n[0], we_n[0]}, 2'b11);
    check("async busy_done", {busy[0], done[0]}, 2'b00);
    check("async rdata", rdata[0], 8'h00);
    hi = 0;
    repeat (3) begin
      @(negedge clk);
      if (done[0]) hi++;
    end
    check("rst no_done", hi, 0);
    reset_n = 1'b1;
    access(1'b1, 3'b001, 3'b001, 8'h5A);
    check("post done0", done_at[0], 3);
    check("post done2", done_at[2], 18);
    check("post rdata", rdata[0], 8'h5A);

    // Random traffic against the model, with rare reset pulses
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      req = 1'($urandom_range(0, 1));
      rw = 1'($urandom_range(0, 1));
      address = 3'($urandom_range(0, 7));
      din = 8'($urandom_range(0, 255));
      reset_n = ($urandom_range(0, 299) != 0);
    end
    @(negedge clk);
    reset_n = 1'b1;
    wait_idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bus_cycle_ctrl.md
# bus_cycle_ctrl

Synchronous bus-cycle sequencer between the CPU-side request interface and the board's memory/peripheral chip selects. It takes the top three address bits of an accepted access and drives exactly one device chip enable (RAM, VIA, ACIA or EEPROM). Around that enable it runs a fixed address-setup cycle, a strobe phase stretched by a per-region wait-state count, and a one-cycle hold. It replaces free-running combinational chip-select decoding for the slow parts.

## Interface
Parameters:
- WS_RAM, 0, extra strobe cycles for RAM (range 0..15)
- WS_VIA, 1, extra strobe cycles for VIA (range 0..15)
- WS_ACIA, 2, extra strobe cycles for ACIA (range 0..15)
- WS_EEPROM, 3, extra strobe cycles for EEPROM (range 0..15)

Ports:
- clk  in  1  system clock; all state changes on the rising edge
- reset_n  in  1  asynchronous, active-low reset
- req  in  1  access request; sampled only in IDLE
- rw  in  1  1 = read, 0 = write; latched with req
- address  in  3  address[15:13] of the access; latched with req
- din  in  8  read data from the device data bus
- eeprom_ce_n  out  1  EEPROM chip enable, active low
- ram_ce_n  out  1  RAM chip enable, active low
- via_ce_n  out  1  VIA chip enable, active low
- acia_ce_n  out  1  ACIA chip enable, active low
- oe_n  out  1  output enable to devices, active low
- we_n  out  1  write enable to devices, active low
- busy  out  1  high whenever state is not IDLE
- done  out  1  one-cycle pulse; the access has completed
- rdata  out  8  captured read data; valid from done onward

## Operation
- Region map, applied to the latched address: 0xx → RAM; 100 or 101 → VIA; 110 → ACIA; 111 → EEPROM.
- At most one ce_n is low at any time. All ce_n are high in IDLE.
- The FSM has four states: IDLE, SETUP, STROBE and HOLD.
- IDLE:
  - All outputs are inactive.
  - When req=1, latch rw and address, load wcnt with the region's WS value, and go to SETUP.
- SETUP (1 cycle):
  - The region ce_n is low; oe_n and we_n stay high.
  - Next state is STROBE.
- STROBE (WS+1 cycles):
  - The region ce_n is low. oe_n=0 if rw=1; we_n=0 if rw=0.
  - If wcnt=0, go to HOLD. Otherwise decrement wcnt.
  - On the final STROBE cycle of a read, capture din into rdata on the clock edge.
- HOLD (1 cycle):
  - oe_n and we_n are high, the region ce_n is still low, and done=1.
  - Next state is IDLE.
- rdata holds its value across writes and across IDLE. It changes only at read capture or reset.
- Changes to req, rw or address after acceptance are ignored. A dropped req does not abort the cycle.
- wcnt is 4 bits wide. It is loaded only in IDLE, so the counter never wraps.

## Timing
- Reset value (reset_n low, asynchronous, taking effect immediately):
  - state = IDLE
  - all ce_n = 1, oe_n = 1, we_n = 1
  - busy = 0, done = 0
  - rdata = 0x00, wcnt = 0
- Reset asserted mid-access aborts the access immediately, with no done pulse. The first req is sampled on the first rising edge after reset_n rises.
- Let the accept edge be E0, the edge at which IDLE samples req=1. The SETUP cycle follows E0.
- Strobe is active for WS+1 cycles. done is high in the cycle that begins WS+3 edges after E0.
- Total occupancy from E0 to return to IDLE is WS+3 cycles. busy is high for exactly those cycles.
- The next req is sampled on the IDLE cycle after HOLD. Minimum request spacing is WS+4 cycles. A req held high continuously produces back-to-back accesses at that rate.
- All outputs are registered or decoded from registered state and latched fields only. No combinational path runs from req, address or rw to any output.

## Structure
- The shared package bus_pkg holds:
  - region_t enum: REG_RAM, REG_VIA, REG_ACIA, REG_EEPROM
  - state_t enum: IDLE, SETUP, STROBE, HOLD
  - WCNT_W = 4
  - function region_of(address[2:0]) → region_t
- One combinational sub-module, bus_region_select, maps (region_t, active) to the four ce_n outputs. It is reused by the later DMA arbiter.
- The top level holds the FSM, wcnt, the latched rw/region, and rdata.

## Test plan
- RAM read with defaults: req=1, rw=1, address=3'b010, din=0xA5.
  - ram_ce_n is low for 3 cycles; oe_n is low for 1 cycle.
  - done appears 3 cycles after E0; rdata=0xA5.
- EEPROM write: address=3'b111, rw=0.
  - we_n is low for 4 cycles; eeprom_ce_n is low for 6 cycles.
  - done appears 6 cycles after E0; rdata is unchanged.
- ACIA read with req held high for three accesses: address=3'b110.
  - done pulses arrive 6 cycles apart.
  - ce_n returns high for exactly 1 IDLE cycle between accesses.
  - Only acia_ce_n ever goes low.
- Address change mid-cycle: accept with VIA address 3'b101, then drive address to 3'b000 during STROBE.
  - via_ce_n stays low to completion; ram_ce_n stays high throughout.
- Reset asserted during the second STROBE cycle of an EEPROM read.
  - All ce_n, oe_n and we_n go high with no clock edge; busy goes to 0; there is no done pulse.
  - rdata reads 0x00, and a new RAM request accepted after release completes normally.
- Parameter override with WS_RAM=2 and a RAM read:
  - strobe lasts 3 cycles and done appears 5 cycles after E0.
  - Repeating with WS_RAM=15 gives done 18 cycles after E0 with no counter wrap.
